// File: rtl/instr_reorder_pkg.sv
// Shared types and classification helpers for the instruction reorder window.
// Holds the scoreboard entry layout and the held-slot record {entry, ctrl-flow flag}.
package instr_reorder_pkg;

  typedef enum logic [2:0] {
    FU_NONE   = 3'd0,
    LOAD      = 3'd1,
    STORE     = 3'd2,
    ALU       = 3'd3,
    CTRL_FLOW = 3'd4,
    MULT      = 3'd5,
    CSR       = 3'd6
  } fu_t;

  typedef struct packed {
    logic       valid;
    logic [7:0] cause;
  } exception_t;

  typedef struct packed {
    logic [31:0] pc;
    fu_t         fu;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    exception_t  ex;
  } scoreboard_entry_t;

  typedef struct packed {
    scoreboard_entry_t sbe;
    logic              is_ctrl_flow;
  } held_t;

  function automatic logic is_mem_op(input scoreboard_entry_t e);
    return (e.fu == LOAD) || (e.fu == STORE);
  endfunction

  // Class filter only; register hazards are checked separately per held slot.
  function automatic logic bypass_class_ok(input scoreboard_entry_t e);
    return !is_mem_op(e) && (e.fu != CTRL_FLOW) && (e.fu != CSR) && !e.ex.valid;
  endfunction

endpackage

// File: rtl/instr_reorder_hazard.sv
// Register hazard between one incoming entry and one held entry; purely combinational.
// Exact 5-bit compares, x0 is not exempt; no flow control.
module instr_reorder_hazard (
  input  logic [4:0] in_rs1_i,
  input  logic [4:0] in_rs2_i,
  input  logic [4:0] in_rd_i,
  input  logic [4:0] held_rs1_i,
  input  logic [4:0] held_rs2_i,
  input  logic [4:0] held_rd_i,
  output logic       hazard_o
);

  // RAW on either source, or WAR/WAW on the destination.
  assign hazard_o = (in_rs1_i == held_rd_i)  ||
                    (in_rs2_i == held_rd_i)  ||
                    (in_rd_i  == held_rs1_i) ||
                    (in_rd_i  == held_rs2_i) ||
                    (in_rd_i  == held_rd_i);

endmodule

// File: rtl/instr_reorder_window.sv
// Holds up to DEPTH memory ops in order while the LSU is busy; hazard-free ALU ops bypass.
// Zero-latency combinational output mux; head forced out after MAX_DELAY bypasses; ack_o is the upstream ready.
module instr_reorder_window
  import instr_reorder_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned MAX_DELAY = 8,
  parameter bit          ENABLE    = 1'b1
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       debug_req_i,
  input  scoreboard_entry_t          issue_entry_i,
  input  logic                       issue_entry_valid_i,
  input  logic                       is_ctrl_flow_i,
  output logic                       issue_instr_ack_o,
  output scoreboard_entry_t          issue_entry_o,
  output logic                       issue_entry_valid_o,
  output logic                       is_ctrl_flow_o,
  input  logic                       issue_instr_ack_i,
  input  logic                       lsu_ready_i,
  output logic [$clog2(DEPTH+1)-1:0] occupancy_o
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned DW = (MAX_DELAY > 0) ? $clog2(MAX_DELAY + 1) : 1;
  localparam logic [CW-1:0] DEPTH_C     = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR    = PW'(DEPTH - 1);
  localparam logic [DW-1:0] MAX_DELAY_C = DW'(MAX_DELAY);

  held_t            mem_q [DEPTH];
  held_t            mem_d [DEPTH];
  logic [DEPTH-1:0] slot_vld_q, slot_vld_d;
  logic [DEPTH-1:0] hz;
  logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic [DW-1:0]    delay_q, delay_d;

  logic  win_en, flush_now, empty, in_mem, hazard_any, elig, bypass, capture;
  logic  push, pop, can_push;
  held_t head_entry;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  for (genvar g = 0; g < DEPTH; g++) begin : g_hz
    instr_reorder_hazard u_hz (
      .in_rs1_i   (issue_entry_i.rs1),
      .in_rs2_i   (issue_entry_i.rs2),
      .in_rd_i    (issue_entry_i.rd),
      .held_rs1_i (mem_q[g].sbe.rs1),
      .held_rs2_i (mem_q[g].sbe.rs2),
      .held_rd_i  (mem_q[g].sbe.rd),
      .hazard_o   (hz[g])
    );
  end

  assign win_en     = ENABLE;
  assign flush_now  = win_en && flush_i;
  assign empty      = !win_en || (count_q == '0);
  assign head_entry = mem_q[head_q];
  assign in_mem     = is_mem_op(issue_entry_i);
  assign hazard_any = |(hz & slot_vld_q);
  assign elig       = issue_entry_valid_i && bypass_class_ok(issue_entry_i) && !hazard_any;
  assign bypass     = !empty && elig && !lsu_ready_i && (delay_q < MAX_DELAY_C) && !debug_req_i;
  assign capture    = win_en && in_mem && issue_entry_valid_i && !lsu_ready_i && !debug_req_i;

  always_comb begin
    issue_entry_o       = issue_entry_i;
    is_ctrl_flow_o      = is_ctrl_flow_i;
    issue_entry_valid_o = issue_entry_valid_i;
    issue_instr_ack_o   = issue_instr_ack_i;
    push                = 1'b0;
    pop                 = 1'b0;
    can_push            = 1'b0;
    delay_d             = delay_q;
    if (flush_now) begin
      issue_entry_valid_o = 1'b0;
      issue_instr_ack_o   = 1'b1;
      delay_d             = '0;
    end else if (!empty) begin
      if (bypass) begin
        if (issue_instr_ack_i) begin
          delay_d = (delay_q == MAX_DELAY_C) ? delay_q : delay_q + DW'(1);
        end
      end else begin
        issue_entry_o       = head_entry.sbe;
        is_ctrl_flow_o      = head_entry.is_ctrl_flow;
        issue_entry_valid_o = 1'b1;
        pop                 = issue_instr_ack_i;
        if (pop) begin
          delay_d = '0;
        end
        can_push          = (count_q < DEPTH_C) || ((count_q == DEPTH_C) && pop);
        // While debug is pending the window only drains; nothing new enters.
        push              = in_mem && issue_entry_valid_i && can_push && !debug_req_i;
        issue_instr_ack_o = push;
      end
    end else if (capture) begin
      push                = 1'b1;
      issue_entry_valid_o = 1'b0;
      issue_instr_ack_o   = 1'b1;
    end
  end

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    slot_vld_d = slot_vld_q;
    mem_d      = mem_q;
    if (flush_now) begin
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      slot_vld_d = '0;
    end else begin
      if (pop) begin
        slot_vld_d[head_q] = 1'b0;
        head_d             = ptr_inc(head_q);
      end
      // Applied after the pop so a full window's shared head/tail slot stays valid.
      if (push) begin
        mem_d[tail_q]      = '{sbe: issue_entry_i, is_ctrl_flow: is_ctrl_flow_i};
        slot_vld_d[tail_q] = 1'b1;
        tail_d             = ptr_inc(tail_q);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      delay_q    <= '0;
      slot_vld_q <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      delay_q    <= delay_d;
      slot_vld_q <= slot_vld_d;
    end
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign occupancy_o = count_q;

endmodule
